// File: rtl/sid_pkg.sv
// SID mixer shared types and constants.
// DIGI_DC is only consumed when SID_MIXER_DIGI_EN is defined.
package sid_pkg;

  localparam int MIX_ACC_W  = 15;
  localparam int MIX_PROD_W = 19;
  localparam int SAMPLE_W   = 16;
  localparam int VOICE_W    = 12;
  localparam int OUT_SHIFT  = 3;

  localparam logic [VOICE_W-1:0] DIGI_DC = 12'h800;

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    ACC2,
    ACC3,
    ACCX,
    SCALE,
    OUT
  } mix_state_t;

endpackage

// File: rtl/sid_mixer_if.sv
// Mixer sample bus: voice/ext inputs, volume, tick and mixed output.
// master = voice side driving the mixer, slave = the mixer itself.
interface sid_mixer_if;
  import sid_pkg::*;

  logic                sample_tick;
  logic [VOICE_W-1:0]  voice1;
  logic [VOICE_W-1:0]  voice2;
  logic [VOICE_W-1:0]  voice3;
  logic [VOICE_W-1:0]  ext_in;
  logic [7:0]          mode_vol;
  logic [SAMPLE_W-1:0] audio_out;
  logic                audio_valid;
  logic                busy;
  logic                overrun;

  modport master (
    output sample_tick,
    output voice1,
    output voice2,
    output voice3,
    output ext_in,
    output mode_vol,
    input  audio_out,
    input  audio_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  sample_tick,
    input  voice1,
    input  voice2,
    input  voice3,
    input  ext_in,
    input  mode_vol,
    output audio_out,
    output audio_valid,
    output busy,
    output overrun
  );

endinterface

// File: rtl/sid_vol_mul.sv
// Registered 15x4 unsigned volume multiply (SCALE stage).
// Kept separate so a DSP primitive can replace it.
module sid_vol_mul
  import sid_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [MIX_ACC_W-1:0]  a,
  input  logic [3:0]            b,
  output logic [MIX_PROD_W-1:0] p
);

  logic [MIX_PROD_W-1:0] p_q;
  logic [MIX_PROD_W-1:0] p_d;

  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = MIX_PROD_W'(a) * MIX_PROD_W'(b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/sid_mixer.sv
// SID output mixer: snapshot, serial accumulate, volume scale, emit.
// Define SID_MIXER_DIGI_EN to start the sum at DIGI_DC (volume digis).
module sid_mixer
  import sid_pkg::*;
(
  input logic      clock,
  input logic      reset_n,
  sid_mixer_if.slave mix
);

  mix_state_t state_q, state_d;

  logic [MIX_ACC_W-1:0]  acc_q, acc_d;
  logic [VOICE_W-1:0]    v1_q, v1_d;
  logic [VOICE_W-1:0]    v2_q, v2_d;
  logic [VOICE_W-1:0]    v3_q, v3_d;
  logic [VOICE_W-1:0]    ext_q, ext_d;
  logic                  v3off_q, v3off_d;
  logic [3:0]            vol_q, vol_d;
  logic [SAMPLE_W-1:0]   out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic [MIX_PROD_W-1:0] prod;
  logic [MIX_ACC_W-1:0]  acc_init;
  logic                  unused_mode;

  assign unused_mode = ^mix.mode_vol[6:4];

`ifdef SID_MIXER_DIGI_EN
  assign acc_init = MIX_ACC_W'(DIGI_DC);
`else
  assign acc_init = '0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    ext_d   = ext_q;
    v3off_d = v3off_q;
    vol_d   = vol_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (mix.sample_tick) begin
          v1_d    = mix.voice1;
          v2_d    = mix.voice2;
          v3_d    = mix.voice3;
          ext_d   = mix.ext_in;
          v3off_d = mix.mode_vol[7];
          vol_d   = mix.mode_vol[3:0];
          acc_d   = acc_init;
          state_d = ACC1;
        end
      end
      ACC1: begin
        acc_d   = acc_q + MIX_ACC_W'(v1_q);
        state_d = ACC2;
      end
      ACC2: begin
        acc_d   = acc_q + MIX_ACC_W'(v2_q);
        state_d = ACC3;
      end
      ACC3: begin
        if (!v3off_q) begin
          acc_d = acc_q + MIX_ACC_W'(v3_q);
        end
        state_d = ACCX;
      end
      ACCX: begin
        acc_d   = acc_q + MIX_ACC_W'(ext_q);
        state_d = SCALE;
      end
      SCALE: begin
        state_d = OUT;
      end
      OUT: begin
        out_d   = SAMPLE_W'(prod >> OUT_SHIFT);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // a tick is only honoured from IDLE; anything else is a lost sample
    if (mix.sample_tick && state_q != IDLE) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      ext_q   <= '0;
      v3off_q <= 1'b0;
      vol_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      ext_q   <= ext_d;
      v3off_q <= v3off_d;
      vol_q   <= vol_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  sid_vol_mul u_mul (
    .clk   (clock),
    .rst_n (reset_n),
    .en    (state_q == SCALE),
    .a     (acc_q),
    .b     (vol_q),
    .p     (prod)
  );

  assign mix.audio_out   = out_q;
  assign mix.audio_valid = valid_q;
  assign mix.busy        = (state_q != IDLE);
  assign mix.overrun     = ovr_q;

endmodule

// File: tb/tb_sid_mixer.sv
// Self-checking bench for sid_mixer: directed literals plus a
// cycle-level behavioural model under randomized tick traffic.
module tb_sid_mixer;
  import sid_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  sid_mixer_if mix_if();

  sid_mixer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mix     (mix_if.slave)
  );

  int checks = 0;
  int passes = 0;

`ifdef SID_MIXER_DIGI_EN
  localparam int DC = 2048;
`else
  localparam int DC = 0;
`endif

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  function automatic int sel(int off_v, int on_v);
`ifdef SID_MIXER_DIGI_EN
    return on_v;
`else
    return off_v;
`endif
  endfunction

  function automatic int mix_val(int a, int b, int c, int x,
                                 logic [7:0] mv);
    int s;
    s = a + b + (mv[7] ? 0 : c) + x + DC;
    return (s * int'(mv[3:0])) / 8;
  endfunction

  // behavioural model: an accepted tick at edge n yields its sample
  // at edge n+6; the block is free again from edge n+7
  int q_edge[$];
  int q_val[$];
  int cyc = 0;
  int next_free = 0;
  int e_out = 0;
  bit e_ovr = 1'b0;
  bit e_valid = 1'b0;
  bit e_busy = 1'b0;

  always @(posedge clock) begin
    if (!reset_n) begin
      q_edge.delete();
      q_val.delete();
      e_out = 0;
      e_ovr = 1'b0;
      e_valid = 1'b0;
      next_free = cyc + 1;
    end else begin
      if (mix_if.sample_tick) begin
        if (cyc >= next_free) begin
          q_edge.push_back(cyc + 6);
          q_val.push_back(mix_val(int'(mix_if.voice1),
            int'(mix_if.voice2), int'(mix_if.voice3),
            int'(mix_if.ext_in), mix_if.mode_vol));
          next_free = cyc + 7;
        end else begin
          e_ovr = 1'b1;
        end
      end
      e_valid = 1'b0;
      if (q_edge.size() > 0 && q_edge[0] == cyc) begin
        e_valid = 1'b1;
        e_out = q_val.pop_front();
        void'(q_edge.pop_front());
      end
    end
    e_busy = (cyc < next_free - 1);
    #1;
    check("m_valid", int'(mix_if.audio_valid), int'(e_valid));
    check("m_busy", int'(mix_if.busy), int'(e_busy));
    check("m_out", int'(mix_if.audio_out), e_out);
    check("m_ovr", int'(mix_if.overrun), int'(e_ovr));
    cyc++;
  end

  task automatic scramble();
    mix_if.voice1 = 12'($urandom);
    mix_if.voice2 = 12'($urandom);
    mix_if.voice3 = 12'($urandom);
    mix_if.ext_in = 12'($urandom);
    mix_if.mode_vol = 8'($urandom);
  endtask

  // call just after a negedge; returns just after a negedge
  task automatic run_tick(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] x,
                          input logic [7:0] mv,
                          output int res, output bit got);
    got = 1'b0;
    res = -1;
    mix_if.voice1 = a;
    mix_if.voice2 = b;
    mix_if.voice3 = c;
    mix_if.ext_in = x;
    mix_if.mode_vol = mv;
    mix_if.sample_tick = 1'b1;
    @(negedge clock);
    mix_if.sample_tick = 1'b0;
    scramble();
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (mix_if.audio_valid) begin
        res = int'(mix_if.audio_out);
        got = 1'b1;
        break;
      end
    end
    @(negedge clock);
    checks++;
    if (got) passes++;
    else $display("FAIL valid_timeout: got none, want pulse");
  endtask

  int r;
  bit g;
  int p;

  initial begin
    mix_if.sample_tick = 1'b0;
    mix_if.voice1 = '0;
    mix_if.voice2 = '0;
    mix_if.voice3 = '0;
    mix_if.ext_in = '0;
    mix_if.mode_vol = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", int'(mix_if.busy), 0);
    check("rst_out", int'(mix_if.audio_out), 0);
    check("rst_valid", int'(mix_if.audio_valid), 0);
    check("rst_ovr", int'(mix_if.overrun), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_tick(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 8'h0F, r, g);
    check("t1_full", r, sel(16'h77F8, 16'h86F8));
    run_tick(12'h100, 12'h000, 12'h000, 12'h000, 8'h08, r, g);
    check("t2_v1", r, sel(16'h0100, 16'h0900));
    run_tick(12'h100, 12'h000, 12'h000, 12'h000, 8'h00, r, g);
    check("t2_vol0", r, 0);
    run_tick(12'h000, 12'h000, 12'hFFF, 12'h000, 8'h8F, r, g);
    check("t3_v3off", r, sel(16'h0000, 16'h0F00));
    run_tick(12'h000, 12'h000, 12'hFFF, 12'h000, 8'h0F, r, g);
    check("t3_v3on", r, sel(16'h1DFE, 16'h2CFE));
    check("t3_no_ovr", int'(mix_if.overrun), 0);

    // second tick at edge 2 is dropped; tick at edge 7 is accepted
    mix_if.voice1 = 12'h100;
    mix_if.voice2 = 12'h100;
    mix_if.voice3 = 12'h100;
    mix_if.ext_in = 12'h100;
    mix_if.mode_vol = 8'h08;
    mix_if.sample_tick = 1'b1;
    @(negedge clock);
    mix_if.sample_tick = 1'b0;
    @(negedge clock);
    mix_if.sample_tick = 1'b1;
    scramble();
    @(negedge clock);
    mix_if.sample_tick = 1'b0;
    check("t4_ovr", int'(mix_if.overrun), 1);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
    check("t4_valid", int'(mix_if.audio_valid), 1);
    check("t4_out", int'(mix_if.audio_out), sel(16'h0400, 16'h0C00));
    @(negedge clock);
    mix_if.voice1 = 12'h200;
    mix_if.voice2 = 12'h000;
    mix_if.voice3 = 12'h000;
    mix_if.ext_in = 12'h000;
    mix_if.mode_vol = 8'h04;
    mix_if.sample_tick = 1'b1;
    @(posedge clock);
    #1;
    check("t4_busy7", int'(mix_if.busy), 1);
    @(negedge clock);
    mix_if.sample_tick = 1'b0;
    g = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (mix_if.audio_valid) begin
        r = int'(mix_if.audio_out);
        g = 1'b1;
        break;
      end
    end
    @(negedge clock);
    check("t4_second", g ? r : -1, sel(16'h0100, 16'h0500));

    // reset during ACC3 aborts the sequence
    mix_if.voice1 = 12'hABC;
    mix_if.mode_vol = 8'h0F;
    mix_if.sample_tick = 1'b1;
    @(negedge clock);
    mix_if.sample_tick = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t5_busy", int'(mix_if.busy), 0);
    check("t5_out", int'(mix_if.audio_out), 0);
    check("t5_ovr", int'(mix_if.overrun), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    run_tick(12'h000, 12'h300, 12'h000, 12'h000, 8'h02, r, g);
    check("t5_after", r, sel(16'h00C0, 16'h02C0));

    run_tick(12'h000, 12'h000, 12'h000, 12'h000, 8'h0F, r, g);
    check("t6_dc", r, sel(16'h0000, 16'h0F00));
    run_tick(12'h000, 12'h000, 12'h000, 12'h000, 8'h00, r, g);
    check("t6_vol0", r, 0);

    for (int k = 0; k < 3000; k++) begin
      p = (k < 1000) ? 5 : (k < 2000) ? 18 : 45;
      scramble();
      mix_if.sample_tick = ($urandom_range(0, 99) < p);
      reset_n = ($urandom_range(0, 499) != 0);
      @(negedge clock);
    end
    reset_n = 1'b1;
    mix_if.sample_tick = 1'b0;
    repeat (10) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
